bnn_vote_accum: RTL and testbench

Output-side decision stage placed directly downstream of the BNN second (4-neuron) layer. It consumes the registered 4-bit class-neuron vector one sample at a time through a valid/ready handshake and accumulates per-class vote counts over a window of `WINDOW` samples. It then resolves the winning class by argmax and presents the result on a held valid/ready output.

---
 rtl/bnn_vote_accum.sv | 154 +++++++++++++++
 tb/tb_bnn_vote_accum.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_vote_accum.sv
// Windowed per-class vote accumulator with argmax/tie resolution behind valid/ready handshakes.
// Optional majority early exit is enabled by defining BNN_VOTE_EARLY_EXIT_EN.
module bnn_vote_accum #(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WINDOW      = 16
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [NUM_CLASSES-1:0]                                 in_class,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [(NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1)-1:0] out_class,
  output logic [CNT_W-1:0]                                       out_count,
  output logic                                                   out_tie,
  output logic                                                   busy
);

  localparam int unsigned CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned SCNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESOLVE,
    S_RESULT
  } state_e;

  state_e                              state_q, state_d;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCNT_W-1:0]                   scnt_q, scnt_d;
  logic [SCNT_W-1:0]                   scnt_inc;
  logic                                out_valid_q, out_valid_d;
  logic [CLS_W-1:0]                    out_class_q, out_class_d;
  logic [CNT_W-1:0]                    out_count_q, out_count_d;
  logic                                out_tie_q, out_tie_d;
  logic [CLS_W-1:0]                    best_idx;
  logic [CNT_W-1:0]                    best_cnt;
  logic                                best_tie;
  logic                                hs;
  logic                                window_done;

  assign in_ready = (state_q == S_ACCUM) && !start;
  assign hs       = in_valid && in_ready;
  assign scnt_inc = scnt_q + SCNT_W'(1);

`ifdef BNN_VOTE_EARLY_EXIT_EN
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(WINDOW / 2 + 1);
  logic majority;

  // A class hitting strict majority on this handshake settles the window early.
  always_comb begin
    majority = 1'b0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if (in_class[i] && ((cnt_q[i] + CNT_W'(1)) == THRESH)) majority = 1'b1;
    end
  end

  assign window_done = (scnt_inc == SCNT_W'(WINDOW)) || majority;
`else
  assign window_done = (scnt_inc == SCNT_W'(WINDOW));
`endif

  // Argmax with lowest index winning equal counts; tie flags any other class at the max.
  always_comb begin
    best_idx = '0;
    best_cnt = cnt_q[0];
    for (int i = 1; i < int'(NUM_CLASSES); i++) begin
      if (cnt_q[i] > best_cnt) begin
        best_idx = CLS_W'(i);
        best_cnt = cnt_q[i];
      end
    end
    best_tie = 1'b0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if ((CLS_W'(i) != best_idx) && (cnt_q[i] == best_cnt)) best_tie = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scnt_d      = scnt_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_count_d = out_count_q;
    out_tie_d   = out_tie_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          scnt_d  = '0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          cnt_d  = '0;
          scnt_d = '0;
        end else if (hs) begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(in_class[i]);
          end
          scnt_d = scnt_inc;
          if (window_done) state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        out_valid_d = 1'b1;
        out_class_d = best_idx;
        out_count_d = best_cnt;
        out_tie_d   = best_tie;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_count_q <= '0;
      out_tie_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_count_q <= out_count_d;
      out_tie_q   <= out_tie_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_count = out_count_q;
  assign out_tie   = out_tie_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bnn_vote_accum.sv
// Self-checking bench for bnn_vote_accum: a WINDOW=4 and a WINDOW=8 instance against a vote-count model.
module tb_bnn_vote_accum;

`ifdef BNN_VOTE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s     [2];
  logic       in_valid_s  [2];
  logic       out_ready_s [2];
  logic [3:0] cls_s       [2];
  logic       in_ready_s  [2];
  logic       out_valid_s [2];
  logic       out_tie_s   [2];
  logic       busy_s      [2];
  logic [1:0] oc_s        [2];
  logic [7:0] ocnt_s      [2];

  int         checks = 0;
  int         errors = 0;
  int         win    [2] = '{4, 8};
  logic [3:0] samp_q [$];
  int         e_cls, e_cnt, e_used;
  bit         e_tie;

  bnn_vote_accum #(.NUM_CLASSES(4), .CNT_W(8), .WINDOW(4)) u_w4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .in_class(cls_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_class(oc_s[0]), .out_count(ocnt_s[0]),
    .out_tie(out_tie_s[0]), .busy(busy_s[0])
  );

  bnn_vote_accum #(.NUM_CLASSES(4), .CNT_W(8), .WINDOW(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .in_class(cls_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_class(oc_s[1]), .out_count(ocnt_s[1]),
    .out_tie(out_tie_s[1]), .busy(busy_s[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: tally votes per class, stop at WINDOW or (early) at first strict majority.
  task automatic model(input int w, input bit early, output int cls, output int cnt,
                       output bit tie, output int used);
    int c[4];
    int mx;
    int nmax;
    bit hit;
    for (int j = 0; j < 4; j++) c[j] = 0;
    used = 0;
    for (int k = 0; k < w && k < samp_q.size(); k++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
        c[j] += int'(samp_q[k][j]);
        if (c[j] >= w / 2 + 1) hit = 1'b1;
      end
      used = k + 1;
      if (early && hit) break;
    end
    mx = 0;
    for (int j = 0; j < 4; j++) if (c[j] > mx) mx = c[j];
    cls = -1;
    nmax = 0;
    for (int j = 0; j < 4; j++) begin
      if (c[j] == mx) begin
        nmax++;
        if (cls < 0) cls = j;
      end
    end
    cnt = mx;
    tie = (nmax > 1);
  endtask

  task automatic do_start(input int d);
    start_s[d] = 1'b1;
    #1;
    checks++;
    if (in_ready_s[d] !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready d=%0d got %0b exp 0", d, in_ready_s[d]);
    end
    step();
    start_s[d] = 1'b0;
    #1;
    checks++;
    if ({in_ready_s[d], busy_s[d], out_valid_s[d]} !== 3'b110) begin
      errors++;
      $display("FAIL accum_entry d=%0d got rdy/busy/ov=%b exp 110",
               d, {in_ready_s[d], busy_s[d], out_valid_s[d]});
    end
  endtask

  task automatic feed(input int d, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid_s[d] = 1'b0;
        cls_s[d] = 4'($urandom_range(0, 15));
        step();
      end
      in_valid_s[d] = 1'b1;
      cls_s[d] = samp_q[k];
      #1;
      checks++;
      if (in_ready_s[d] !== 1'b1) begin
        errors++;
        $display("FAIL sample_ready d=%0d k=%0d got %0b exp 1", d, k, in_ready_s[d]);
      end
      step();
    end
    in_valid_s[d] = 1'b0;
    cls_s[d] = 4'd0;
  endtask

  task automatic check_result(input int d);
    #1;
    checks++;
    if ({out_valid_s[d], busy_s[d], in_ready_s[d]} !== 3'b010) begin
      errors++;
      $display("FAIL resolve_cycle d=%0d got ov/busy/rdy=%b exp 010",
               d, {out_valid_s[d], busy_s[d], in_ready_s[d]});
    end
    step();
    checks++;
    if ({out_valid_s[d], oc_s[d], ocnt_s[d], out_tie_s[d]} !== {1'b1, 2'(e_cls), 8'(e_cnt), e_tie}) begin
      errors++;
      $display("FAIL result d=%0d got v=%0b cls=%0d cnt=%0d tie=%0b exp v=1 cls=%0d cnt=%0d tie=%0b",
               d, out_valid_s[d], oc_s[d], ocnt_s[d], out_tie_s[d], e_cls, e_cnt, e_tie);
    end
  endtask

  task automatic finish(input int d, input int delay, input bit pulse);
    logic [10:0] held;
    held = {oc_s[d], ocnt_s[d], out_tie_s[d]};
    for (int k = 0; k < delay; k++) begin
      in_valid_s[d] = 1'b1;
      start_s[d] = pulse && (k == 1);
      step();
      start_s[d] = 1'b0;
      #1;
      checks++;
      if ({out_valid_s[d], busy_s[d], in_ready_s[d], oc_s[d], ocnt_s[d], out_tie_s[d]} !== {3'b110, held}) begin
        errors++;
        $display("FAIL hold d=%0d k=%0d got ov/busy/rdy=%b out=%h exp 110 out=%h", d, k,
                 {out_valid_s[d], busy_s[d], in_ready_s[d]}, {oc_s[d], ocnt_s[d], out_tie_s[d]}, held);
      end
    end
    in_valid_s[d] = 1'b0;
    out_ready_s[d] = 1'b1;
    step();
    out_ready_s[d] = 1'b0;
    checks++;
    if ({out_valid_s[d], busy_s[d], in_ready_s[d]} !== 3'b000) begin
      errors++;
      $display("FAIL release d=%0d got ov/busy/rdy=%b exp 000", d, {out_valid_s[d], busy_s[d], in_ready_s[d]});
    end
    if (pulse) begin
      step();
      checks++;
      if (busy_s[d] !== 1'b0) begin
        errors++;
        $display("FAIL start_not_queued d=%0d got busy=%0b exp 0", d, busy_s[d]);
      end
    end
  endtask

  task automatic run_window(input int d, input bit gaps, input int delay);
    model(win[d], EARLY, e_cls, e_cnt, e_tie, e_used);
    do_start(d);
    feed(d, e_used, gaps);
    check_result(d);
    finish(d, delay, 1'b0);
  endtask

  task automatic fill_random(input int n);
    samp_q = {};
    for (int k = 0; k < n; k++) samp_q.push_back(4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      in_valid_s[d] = 1'b0;
      out_ready_s[d] = 1'b0;
      cls_s[d] = 4'd0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({in_ready_s[d], out_valid_s[d], oc_s[d], ocnt_s[d], out_tie_s[d], busy_s[d]} !== 14'd0) begin
        errors++;
        $display("FAIL reset_values d=%0d got %h exp 0", d,
                 {in_ready_s[d], out_valid_s[d], oc_s[d], ocnt_s[d], out_tie_s[d], busy_s[d]});
      end
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    samp_q = {4'b0001, 4'b0011, 4'b0010, 4'b0010};
    run_window(0, 1'b0, 0);
  endtask

  task automatic test_tie_empty();
    samp_q = {4'b0101, 4'b0101, 4'b0101, 4'b0101};
    run_window(0, 1'b0, 0);
    samp_q = {4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_window(0, 1'b0, 1);
  endtask

  task automatic test_backpressure();
    samp_q = {4'b0100, 4'b0110, 4'b1000, 4'b0010};
    model(win[0], EARLY, e_cls, e_cnt, e_tie, e_used);
    do_start(0);
    feed(0, e_used, 1'b0);
    check_result(0);
    finish(0, 5, 1'b1);
  endtask

  task automatic test_restart(input logic [3:0] pre, input logic [3:0] p0, input logic [3:0] p1,
                              input logic [3:0] p2, input logic [3:0] p3);
    samp_q = {pre, pre};
    do_start(0);
    feed(0, 2, 1'b0);
    start_s[0] = 1'b1;
    in_valid_s[0] = 1'b1;
    cls_s[0] = pre;
    #1;
    checks++;
    if (in_ready_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL restart_ready got %0b exp 0", in_ready_s[0]);
    end
    step();
    start_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    samp_q = {p0, p1, p2, p3};
    model(win[0], EARLY, e_cls, e_cnt, e_tie, e_used);
    feed(0, e_used, 1'b0);
    check_result(0);
    finish(0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    samp_q = {4'b0001, 4'b0010};
    do_start(0);
    feed(0, 2, 1'b0);
    in_valid_s[0] = 1'b1;
    cls_s[0] = 4'b0001;
    #1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready_s[0], out_valid_s[0], oc_s[0], ocnt_s[0], out_tie_s[0], busy_s[0]} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset_accum got %h exp 0",
               {in_ready_s[0], out_valid_s[0], oc_s[0], ocnt_s[0], out_tie_s[0], busy_s[0]});
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({in_ready_s[0], busy_s[0]} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d got rdy/busy=%b exp 00", k, {in_ready_s[0], busy_s[0]});
      end
    end
    in_valid_s[0] = 1'b0;
    samp_q = {4'b0010, 4'b0010, 4'b0010, 4'b0010};
    model(win[0], EARLY, e_cls, e_cnt, e_tie, e_used);
    do_start(0);
    feed(0, e_used, 1'b0);
    check_result(0);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid_s[0], oc_s[0], ocnt_s[0], out_tie_s[0], busy_s[0]} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset_result got %h exp 0",
               {out_valid_s[0], oc_s[0], ocnt_s[0], out_tie_s[0], busy_s[0]});
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_early_exit();
    samp_q = {4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    run_window(1, 1'b0, 0);
    for (int n = 0; n < 4; n++) begin
      fill_random(8);
      run_window(1, 1'b1, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      fill_random(4);
      run_window(0, 1'b1, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      fill_random(4);
      run_window(0, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_empty();
    test_backpressure();
    test_restart(4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
    test_restart(4'b1000, 4'b0100, 4'b0001, 4'b0000, 4'b0000);
    test_async_reset();
    test_early_exit();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
